uart_rx_fsm: RTL and testbench
==============================

// Module: uart_rx_fsm
// PURPOSE
//   Main controller of the UART receiver. Sequences one frame (start, data, optional parity, stop).
//   Drives the enables of the edge/bit counter, data sampler, start/parity/stop checkers and deserializer.
//   Consumes the checker error flags and issues a single-cycle data_valid per good frame.
//   Sits between the rx_in line and the UART_RX datapath sub-blocks.
// PARAMETERS
//   DATA_WIDTH  8  data bits per frame; bit_count value of the last data bit
// PORTS
//   clk             in   1  receiver clock (oversampling clock, Prescale ticks per bit)
//   rst             in   1  synchronous, active-high reset
//   rx_in           in   1  serial line; already synchronized upstream; idle = 1
//   PAR_EN          in   1  1 = parity bit present after data bits
//   Prescale        in   6  oversampling ratio; legal 8, 16, 32; held stable while rx_busy=1
//   edge_count      in   5  edge counter value within current bit, 0..Prescale-1
//   bit_count       in   4  current bit index: 0 start, 1..DATA_WIDTH data, then parity/stop
//   start_glitch    in   1  registered flag from start checker
//   parity_error    in   1  registered flag from parity checker
//   stop_error      in   1  registered flag from stop checker
//   edge_cnt_en     out  1  runs edge/bit counters; low = counters cleared
//   dat_samp_en     out  1  enables data sampler
//   start_check_en  out  1  enables start checker
//   deser_en        out  1  enables deserializer shifting
//   par_check_en    out  1  enables parity checker
//   stop_check_en   out  1  enables stop checker
//   data_valid      out  1  one-cycle pulse: frame received without error
//   rx_busy         out  1  high in every state except IDLE
// BEHAVIOUR
//   States: IDLE, START, DATA, PARITY, STOP, CHECK; one-hot or binary, single registered state.
//   Reset: state=IDLE; every output 0. Reset mid-frame: IDLE on the next edge, frame discarded.
//   All outputs are Moore decodes of the state register except data_valid (state + error flags).
//   "bit end" = edge_count == Prescale-1.
//   IDLE:   outputs 0. rx_in==0 -> START; else stay.
//   START:  edge_cnt_en, dat_samp_en, start_check_en = 1. At bit end:
//           start_glitch=1 -> IDLE (no deser_en ever raised); else -> DATA.
//   DATA:   edge_cnt_en, dat_samp_en, deser_en = 1. At bit end with bit_count==DATA_WIDTH:
//           PAR_EN=1 -> PARITY; else -> STOP. Other bit ends: stay.
//   PARITY: edge_cnt_en, dat_samp_en, par_check_en = 1. At bit end -> STOP.
//   STOP:   edge_cnt_en, dat_samp_en, stop_check_en = 1. At bit end -> CHECK.
//   CHECK:  one cycle, edge_cnt_en=0 (counters clear). data_valid = !parity_error & !stop_error
//           (parity_error ignored when PAR_EN=0). Next: rx_in==0 -> START, else IDLE.
//   Back-to-back frames: new start seen in CHECK enters START directly; START bit timing is
//     measured from that entry (one-cycle slip accepted, within half-bit sampling margin).
//   rx_in is not looked at outside IDLE and CHECK; line noise mid-frame is the checkers' job.
//   PAR_EN/Prescale changes while rx_busy=1: undefined frame result, FSM still returns to IDLE.
//   Latency: data_valid asserts exactly 1 cycle after the stop bit end.
//   Frame length (cycles from START entry to CHECK): Prescale*(DATA_WIDTH+2+PAR_EN).
// TESTING
//   1 Prescale=8, PAR_EN=0, frame 0xA5 good -> START/DATA/STOP seq, data_valid one pulse at cycle 80 after START, deser_en 64 cycles.
//   2 Prescale=8, rx_in low 2 cycles, start_glitch=1 at edge 6 -> IDLE after edge 7, deser_en/data_valid never high.
//   3 Prescale=16, PAR_EN=1, parity_error=1 -> PARITY entered after bit 8, data_valid stays 0, back to IDLE.
//   4 Prescale=32, PAR_EN=0, stop_error=1 -> data_valid 0; then good frame -> data_valid 1.
//   5 Two frames back-to-back (rx_in=0 during CHECK) -> CHECK->START direct, two data_valid pulses.
//   6 rst=1 during DATA (bit_count=4) -> next cycle IDLE, all outputs 0, no data_valid.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: walks start, data, optional parity and stop bits,
// enables the datapath sub-blocks and flags each error-free frame with data_valid.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic [4:0] edge_count,
  input  logic [3:0] bit_count,
  input  logic       start_glitch,
  input  logic       parity_error,
  input  logic       stop_error,
  output logic       edge_cnt_en,
  output logic       dat_samp_en,
  output logic       start_check_en,
  output logic       deser_en,
  output logic       par_check_en,
  output logic       stop_check_en,
  output logic       data_valid,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

  state_t state_r;
  state_t next_s;
  logic   bit_end_s;
  logic   last_bit_s;
  logic   frame_ok_s;

  assign bit_end_s  = ({1'b0, edge_count} == (Prescale - 6'd1));
  assign last_bit_s = (bit_count == LAST_BIT);
  // Flags are sampled on the stop-bit end so the registered pulse lands in CHECK.
  assign frame_ok_s = !stop_error && !(PAR_EN && parity_error);

  // Next-state selection from the current state, line and counter position.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_in) next_s = START;
        else        next_s = IDLE;
      end
      START: begin
        if (bit_end_s) next_s = start_glitch ? IDLE : DATA;
        else           next_s = START;
      end
      DATA: begin
        if (bit_end_s && last_bit_s) next_s = PAR_EN ? PARITY : STOP;
        else                         next_s = DATA;
      end
      PARITY: begin
        if (bit_end_s) next_s = STOP;
        else           next_s = PARITY;
      end
      STOP: begin
        if (bit_end_s) next_s = CHECK;
        else           next_s = STOP;
      end
      CHECK: begin
        if (!rx_in) next_s = START;
        else        next_s = IDLE;
      end
      default: next_s = IDLE;
    endcase
  end

  // State register with outputs decoded from the upcoming state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      edge_cnt_en    <= 1'b0;
      dat_samp_en    <= 1'b0;
      start_check_en <= 1'b0;
      deser_en       <= 1'b0;
      par_check_en   <= 1'b0;
      stop_check_en  <= 1'b0;
      data_valid     <= 1'b0;
      rx_busy        <= 1'b0;
    end else begin
      state_r        <= next_s;
      edge_cnt_en    <= 1'b0;
      dat_samp_en    <= 1'b0;
      start_check_en <= 1'b0;
      deser_en       <= 1'b0;
      par_check_en   <= 1'b0;
      stop_check_en  <= 1'b0;
      data_valid     <= (state_r == STOP) && (next_s == CHECK) && frame_ok_s;
      rx_busy        <= (next_s != IDLE);
      case (next_s)
        START: begin
          edge_cnt_en    <= 1'b1;
          dat_samp_en    <= 1'b1;
          start_check_en <= 1'b1;
        end
        DATA: begin
          edge_cnt_en <= 1'b1;
          dat_samp_en <= 1'b1;
          deser_en    <= 1'b1;
        end
        PARITY: begin
          edge_cnt_en  <= 1'b1;
          dat_samp_en  <= 1'b1;
          par_check_en <= 1'b1;
        end
        STOP: begin
          edge_cnt_en   <= 1'b1;
          dat_samp_en   <= 1'b1;
          stop_check_en <= 1'b1;
        end
        default: begin
          edge_cnt_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized self-checking bench for uart_rx_fsm; expected outputs come from the frame
// cycle index and bit-timing arithmetic, with the edge/bit counters emulated from that index.
module tb_uart_rx_fsm;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic [4:0] edge_count;
  logic [3:0] bit_count;
  logic       start_glitch;
  logic       parity_error;
  logic       stop_error;
  logic       edge_cnt_en, dat_samp_en, start_check_en, deser_en;
  logic       par_check_en, stop_check_en, data_valid, rx_busy;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fsm #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .edge_count(edge_count), .bit_count(bit_count), .start_glitch(start_glitch),
    .parity_error(parity_error), .stop_error(stop_error),
    .edge_cnt_en(edge_cnt_en), .dat_samp_en(dat_samp_en), .start_check_en(start_check_en),
    .deser_en(deser_en), .par_check_en(par_check_en), .stop_check_en(stop_check_en),
    .data_valid(data_valid), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  assign outs = {edge_cnt_en, dat_samp_en, start_check_en, deser_en,
                 par_check_en, stop_check_en, data_valid, rx_busy};

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rx_in        = 1'b1;
    edge_count   = 5'd0;
    bit_count    = 4'd0;
    start_glitch = 1'b0;
    parity_error = 1'b0;
    stop_error   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_eq("idle", outs, 8'b0000_0000);
      drive_idle();
    end
  endtask

  // One frame starting with START entry at the next edge; k = cycles since START entry.
  task automatic run_frame(input int p, input bit pe, input bit glitch, input bit perr,
                           input bit serr, input bit b2b, input int rst_at, output bit chained);
    int len;
    logic [7:0] e;
    logic dv;
    len = p * (W + 2 + int'(pe));
    dv = !serr && !(pe && perr);
    chained = 1'b0;
    for (int k = 0; k <= len + 1; k++) begin
      step();
      if (rst_at >= 0 && k == rst_at + 1) begin
        check_eq("reset_mid", outs, 8'b0000_0000);
        rst = 1'b0;
        drive_idle();
        return;
      end
      if (k < p)                          e = 8'b1110_0001;
      else if (glitch)                    e = 8'b0000_0000;
      else if (k < p * (W + 1))           e = 8'b1101_0001;
      else if (pe && k < p * (W + 2))     e = 8'b1100_1001;
      else if (k < len)                   e = 8'b1100_0101;
      else if (k == len)                  e = {6'b000000, dv, 1'b1};
      else                                e = 8'b0000_0000;
      check_eq(k == len ? "check_state" : "frame", outs, e);
      if (glitch && k == p) begin
        drive_idle();
        return;
      end
      if (k < len) begin
        edge_count = 5'(k % p);
        bit_count  = 4'(k / p);
        rx_in      = 1'($urandom_range(0, 1));
      end else begin
        edge_count = 5'd0;
        bit_count  = 4'd0;
        rx_in      = (k == len) ? !b2b : 1'b1;
      end
      start_glitch = glitch && (k >= p - 2) && (k < p);
      parity_error = perr && (k >= p * (W + 1)) && (k < len);
      stop_error   = serr && (k >= p * (W + 1 + int'(pe))) && (k < len);
      if (k == rst_at) rst = 1'b1;
      if (k == len && b2b) begin
        chained = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_frame(input int p, input bit pe, input bit glitch, input bit perr,
                          input bit serr, input bit b2b, input int rst_at);
    bit chained;
    idle_cycles(2);
    Prescale = 6'(p);
    PAR_EN   = pe;
    rx_in    = 1'b0;
    run_frame(p, pe, glitch, perr, serr, b2b, rst_at, chained);
    if (chained) run_frame(p, pe, 1'b0, 1'b0, 1'b0, 1'b0, -1, chained);
  endtask

  initial begin
    int p, len, rst_at;
    bit pe, glitch, perr, serr, b2b;
    rst = 1'b1;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    drive_idle();
    rx_in = 1'b0;
    repeat (3) step();
    check_eq("reset_state", outs, 8'b0000_0000);
    rst = 1'b0;
    rx_in = 1'b1;

    do_frame(8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    do_frame(8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    do_frame(16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    do_frame(32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    do_frame(32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    do_frame(8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    do_frame(16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    do_frame(8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8 * 4 + 3);

    for (int i = 0; i < 40; i++) begin
      p      = 8 << $urandom_range(0, 2);
      pe     = 1'($urandom_range(0, 1));
      glitch = ($urandom_range(0, 5) == 0);
      perr   = 1'($urandom_range(0, 1));
      serr   = ($urandom_range(0, 3) == 0);
      b2b    = 1'($urandom_range(0, 1));
      len    = p * (W + 2 + int'(pe));
      rst_at = (!glitch && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      do_frame(p, pe, glitch, perr, serr, b2b, rst_at);
    end
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
